// File: rtl/spi_wavetable_regfile.sv
// SPI Mode 0 register slave for the wavetable synth.
// Command byte {R/nW, addr[6:0]} is followed by data bytes, and the address auto-increments.
// Voice writes are staged in shadow registers and go live together when CS is released.
// Optional macro SPI_READBACK_EN drives register data on spi_miso for read commands.
// Without that macro, spi_miso is tied low.
module spi_wavetable_regfile #(
  parameter int unsigned WT_DEPTH    = 16,
  parameter int unsigned NUM_VOICES  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_sck,
  input  logic                       spi_mosi,
  input  logic                       spi_cs,
  output logic                       spi_miso,
  input  logic                       status_gate_active,
  input  logic                       status_osc_running,
  output logic [7:0]                 reg_control,
  output logic [7:0]                 reg_status,
  output logic [24*NUM_VOICES-1:0]   freq_bus,
  output logic [8*NUM_VOICES-1:0]    volume_bus,
  output logic [8*WT_DEPTH-1:0]      wavetable_bus,
  output logic                       commit_pulse
);

  localparam int unsigned S = SYNC_STAGES;
  localparam logic [6:0] VoiceEnd = 7'(2 + 4 * NUM_VOICES);
  localparam logic [6:0] WtBase   = 7'h10;
  localparam logic [6:0] WtEnd    = 7'(16 + WT_DEPTH);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  logic [S-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;

  // Input synchronisers; index 0 is nearest the pin. CS idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
    end else begin
      sck_sync_q  <= {sck_sync_q[S-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[S-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[S-2:0], spi_cs};
    end
  end

  logic sck_rise, cs_fall, cs_rise, mosi_s;
  assign sck_rise = sck_sync_q[S-2] & ~sck_sync_q[S-1];
  assign cs_fall  = ~cs_sync_q[S-2] & cs_sync_q[S-1];
  assign cs_rise  = cs_sync_q[S-2] & ~cs_sync_q[S-1];
  // MOSI is stable for half an SCK period before the rising edge, so the oldest stage is safe.
  assign mosi_s   = mosi_sync_q[S-1];

  state_e                       state_q, state_d;
  logic [2:0]                   bit_cnt_q, bit_cnt_d;
  logic [6:0]                   shift_q, shift_d;
  logic [6:0]                   addr_q, addr_d;
  logic                         rnw_q, rnw_d;
  logic [7:0]                   control_q, control_d;
  logic [WT_DEPTH-1:0][7:0]     wt_q, wt_d;
  logic [NUM_VOICES-1:0][23:0]  freq_sh_q, freq_sh_d, freq_q, freq_d;
  logic [NUM_VOICES-1:0][7:0]   vol_sh_q, vol_sh_d, vol_q, vol_d;
  logic                         dirty_q, dirty_d;
  logic                         commit_q, commit_d;

  logic [7:0] byte_in;
  logic [6:0] voff, wt_idx;
  logic       byte_done, wr_en, voice_hit, wt_hit;

  assign byte_in   = {shift_q, mosi_s};
  // A byte that completes in the same clk as the CS release is treated as aborted.
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7) && !cs_rise;
  assign wr_en     = byte_done && (state_q == StData) && !rnw_q;
  assign voff      = addr_q - 7'd2;
  assign wt_idx    = addr_q - WtBase;
  assign voice_hit = (addr_q >= 7'd2) && (addr_q < VoiceEnd);
  assign wt_hit    = (addr_q >= WtBase) && (addr_q < WtEnd);

  assign reg_status = {6'b0, status_osc_running, status_gate_active};

`ifdef SPI_READBACK_EN
  logic       sck_fall;
  logic       miso_q, miso_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rd_data;

  assign sck_fall = ~sck_sync_q[S-2] & sck_sync_q[S-1];

  // Read mux; voice reads return live values.
  always_comb begin
    rd_data = 8'h00;
    if (addr_q == 7'h00) begin
      rd_data = control_q;
    end else if (addr_q == 7'h01) begin
      rd_data = reg_status;
    end else if (voice_hit) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (voff[6:2] == 5'(v)) begin
          unique case (voff[1:0])
            2'd0:    rd_data = freq_q[v][7:0];
            2'd1:    rd_data = freq_q[v][15:8];
            2'd2:    rd_data = freq_q[v][23:16];
            default: rd_data = vol_q[v];
          endcase
        end
      end
    end else if (wt_hit) begin
      for (int unsigned n = 0; n < WT_DEPTH; n++) begin
        if (wt_idx == 7'(n)) rd_data = wt_q[n];
      end
    end
  end

  // MISO shifter: load a byte on the first falling edge of each data byte, then shift.
  always_comb begin
    miso_d = miso_q;
    tx_d   = tx_q;
    if (state_q == StData && rnw_q && sck_fall) begin
      if (bit_cnt_q == 3'd0) begin
        miso_d = rd_data[7];
        tx_d   = {rd_data[6:0], 1'b0};
      end else begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
    if (state_q == StIdle || cs_rise) begin
      miso_d = 1'b0;
      tx_d   = 8'h00;
    end
  end

  // MISO state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
      tx_q   <= 8'h00;
    end else begin
      miso_q <= miso_d;
      tx_q   <= tx_d;
    end
  end

  assign spi_miso = miso_q;
`else
  assign spi_miso = 1'b0;
`endif

  // Frame FSM, register writes and shadow commit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    control_d = control_q;
    wt_d      = wt_q;
    freq_sh_d = freq_sh_q;
    vol_sh_d  = vol_sh_q;
    freq_d    = freq_q;
    vol_d     = vol_q;
    dirty_d   = dirty_q;
    commit_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 3'd0;
        if (cs_fall) state_d = StCmd;
      end
      StCmd: begin
        if (sck_rise) begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rnw_d   = byte_in[7];
            addr_d  = byte_in[6:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sck_rise) begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) addr_d = addr_q + 7'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      if (addr_q == 7'h00) control_d = byte_in;
      if (voice_hit) begin
        dirty_d = 1'b1;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (voff[6:2] == 5'(v)) begin
            unique case (voff[1:0])
              2'd0:    freq_sh_d[v][7:0]   = byte_in;
              2'd1:    freq_sh_d[v][15:8]  = byte_in;
              2'd2:    freq_sh_d[v][23:16] = byte_in;
              default: vol_sh_d[v]         = byte_in;
            endcase
          end
        end
      end
      if (wt_hit) begin
        for (int unsigned n = 0; n < WT_DEPTH; n++) begin
          if (wt_idx == 7'(n)) wt_d[n] = byte_in;
        end
      end
    end

    if (cs_rise) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      if (dirty_q) begin
        freq_d   = freq_sh_q;
        vol_d    = vol_sh_q;
        commit_d = 1'b1;
        dirty_d  = 1'b0;
      end
    end
  end

  // Register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      addr_q    <= 7'd0;
      rnw_q     <= 1'b0;
      control_q <= 8'h00;
      wt_q      <= '0;
      freq_sh_q <= '0;
      vol_sh_q  <= '0;
      freq_q    <= '0;
      vol_q     <= '0;
      dirty_q   <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      rnw_q     <= rnw_d;
      control_q <= control_d;
      wt_q      <= wt_d;
      freq_sh_q <= freq_sh_d;
      vol_sh_q  <= vol_sh_d;
      freq_q    <= freq_d;
      vol_q     <= vol_d;
      dirty_q   <= dirty_d;
      commit_q  <= commit_d;
    end
  end

  assign reg_control   = control_q;
  assign freq_bus      = freq_q;
  assign volume_bus    = vol_q;
  assign wavetable_bus = wt_q;
  assign commit_pulse  = commit_q;

endmodule

// File: tb/tb_spi_wavetable_regfile.sv
// Self-checking bench for spi_wavetable_regfile with default parameters.
module tb_spi_wavetable_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_miso;
  logic        status_gate_active = 1'b0;
  logic        status_osc_running = 1'b0;
  logic [7:0]  reg_control;
  logic [7:0]  reg_status;
  logic [47:0] freq_bus;
  logic [15:0] volume_bus;
  logic [127:0] wavetable_bus;
  logic        commit_pulse;

  spi_wavetable_regfile dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .spi_sck            (spi_sck),
    .spi_mosi           (spi_mosi),
    .spi_cs             (spi_cs),
    .spi_miso           (spi_miso),
    .status_gate_active (status_gate_active),
    .status_osc_running (status_osc_running),
    .reg_control        (reg_control),
    .reg_status         (reg_status),
    .freq_bus           (freq_bus),
    .volume_bus         (volume_bus),
    .wavetable_bus      (wavetable_bus),
    .commit_pulse       (commit_pulse)
  );

  always #5 clk = ~clk;

  int unsigned pulse_cycles = 0;
  always @(posedge clk) begin
    if (commit_pulse) pulse_cycles <= pulse_cycles + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] view;
    logic [23:0] exp;
    int unsigned pulses;
  } vec_t;

  typedef struct {
    string       name;
    logic [7:0]  view;
    logic [23:0] exp;
    int unsigned pulses;
  } sb_t;

  vec_t vecs[11];
  sb_t  sb_q[$];

  // Views: 00 control, 01 status, 8v full freq, 9v volume, A0+n wavetable sample n.
  function automatic logic [23:0] obs(input logic [7:0] v);
    logic [23:0] r;
    r = 24'h0;
    if (v == 8'h00) r = {16'h0, reg_control};
    else if (v == 8'h01) r = {16'h0, reg_status};
    else if (v == 8'h80) r = freq_bus[23:0];
    else if (v == 8'h81) r = freq_bus[47:24];
    else if (v == 8'h90) r = {16'h0, volume_bus[7:0]};
    else if (v == 8'h91) r = {16'h0, volume_bus[15:8]};
    else if (v[7:4] == 4'hA) r = {16'h0, wavetable_bus[8*v[3:0] +: 8]};
    return r;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #80;
      spi_sck = 1'b1;
      rx[i] = spi_miso;
      #80;
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_cs = 1'b0;
    #80;
  endtask

  task automatic frame_end();
    #80;
    spi_cs = 1'b1;
    #200;
  endtask

  task automatic write_frame(input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] rx;
    frame_begin();
    spi_byte({1'b0, addr}, rx);
    spi_byte(data, rx);
    frame_end();
  endtask

  initial begin
    logic [7:0] rx;
    int unsigned p0;
    sb_t e;

    vecs[0]  = '{"ctrl_05",      7'h00, 8'h05, 8'h00, 24'h05,     0};
    vecs[1]  = '{"ctrl_ff",      7'h00, 8'hFF, 8'h00, 24'hFF,     0};
    vecs[2]  = '{"status_ro",    7'h01, 8'h77, 8'h01, 24'h00,     0};
    vecs[3]  = '{"wt_first",     7'h10, 8'h3C, 8'hA0, 24'h3C,     0};
    vecs[4]  = '{"wt_last",      7'h1F, 8'hC3, 8'hAF, 24'hC3,     0};
    vecs[5]  = '{"v0_freq_lo",   7'h02, 8'h11, 8'h80, 24'h000011, 1};
    vecs[6]  = '{"v0_vol",       7'h05, 8'h42, 8'h90, 24'h42,     1};
    vecs[7]  = '{"v1_vol",       7'h09, 8'h80, 8'h91, 24'h80,     1};
    vecs[8]  = '{"wt_past_end",  7'h20, 8'h99, 8'hAF, 24'hC3,     0};
    vecs[9]  = '{"voice_past",   7'h0A, 8'h55, 8'h81, 24'h0,      0};
    vecs[10] = '{"ctrl_03",      7'h00, 8'h03, 8'h00, 24'h03,     0};

    #2;
    #30;
    check("reset_control", {16'h0, reg_control}, 24'h0);
    check("reset_freq", freq_bus[23:0] | freq_bus[47:24], 24'h0);
    check("reset_vol_wt", {23'h0, (|volume_bus) | (|wavetable_bus)}, 24'h0);
    check("reset_commit_miso", {22'h0, commit_pulse, spi_miso}, 24'h0);
    rst_n = 1'b1;
    #50;

    // Table-driven single-byte write frames with scoreboard.
    foreach (vecs[i]) begin
      sb_q.push_back('{vecs[i].name, vecs[i].view, vecs[i].exp, vecs[i].pulses});
      p0 = pulse_cycles;
      write_frame(vecs[i].addr, vecs[i].data);
      e = sb_q.pop_front();
      check(e.name, obs(e.view), e.exp);
      check({e.name, "_pulse"}, 24'(pulse_cycles - p0), 24'(e.pulses));
    end

    // Live status view.
    status_gate_active = 1'b1;
    #10;
    check("status_gate", {16'h0, reg_status}, 24'h01);
    status_osc_running = 1'b1;
    #10;
    check("status_both", {16'h0, reg_status}, 24'h03);
    status_gate_active = 1'b0;
    status_osc_running = 1'b0;

    // Voice 1 burst: values stay staged until CS rises.
    p0 = pulse_cycles;
    frame_begin();
    spi_byte(8'h06, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h40, rx);
    spi_byte(8'h02, rx);
    spi_byte(8'h80, rx);
    #80;
    check("v1_staged", freq_bus[47:24], 24'h0);
    check("v1_no_early_pulse", 24'(pulse_cycles - p0), 24'h0);
    spi_cs = 1'b1;
    #200;
    check("v1_freq", freq_bus[47:24], 24'h024000);
    check("v1_vol_burst", {16'h0, volume_bus[15:8]}, 24'h80);
    check("v1_pulse_width", 24'(pulse_cycles - p0), 24'h1);

    // Wavetable burst 0, 17, ..., 255.
    frame_begin();
    spi_byte(8'h10, rx);
    for (int n = 0; n < 16; n++) spi_byte(8'(n * 17), rx);
    frame_end();
    for (int n = 0; n < 16; n++) begin
      check($sformatf("wt_burst_%0d", n), {16'h0, wavetable_bus[8*n +: 8]}, 24'(n * 17));
    end

    // Abort: CS rises after 5 data bits.
    p0 = pulse_cycles;
    frame_begin();
    spi_byte(8'h02, rx);
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      #80;
      spi_sck = 1'b1;
      #80;
      spi_sck = 1'b0;
    end
    frame_end();
    check("abort_freq", freq_bus[23:0], 24'h000011);
    check("abort_no_pulse", 24'(pulse_cycles - p0), 24'h0);
    p0 = pulse_cycles;
    write_frame(7'h02, 8'h5A);
    check("after_abort_freq", freq_bus[23:0], 24'h00005A);
    check("after_abort_pulse", 24'(pulse_cycles - p0), 24'h1);

    // Reset mid-frame after a staged voice byte.
    frame_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h77, rx);
    #40;
    rst_n = 1'b0;
    #30;
    check("rst_mid_control", {16'h0, reg_control}, 24'h0);
    check("rst_mid_freq", freq_bus[23:0] | freq_bus[47:24], 24'h0);
    check("rst_mid_vol_wt", {23'h0, (|volume_bus) | (|wavetable_bus)}, 24'h0);
    spi_cs = 1'b1;
    #30;
    rst_n = 1'b1;
    #50;
    p0 = pulse_cycles;
    write_frame(7'h00, 8'h06);
    check("post_rst_control", {16'h0, reg_control}, 24'h06);
    check("post_rst_no_commit", 24'(pulse_cycles - p0) | freq_bus[23:0], 24'h0);

`ifdef SPI_READBACK_EN
    write_frame(7'h12, 8'hA5);
    frame_begin();
    spi_byte(8'h92, rx);
    spi_byte(8'h00, rx);
    frame_end();
    check("readback_wt2", {16'h0, rx}, 24'hA5);
    check("readback_no_write", {16'h0, wavetable_bus[23:16]}, 24'hA5);
    status_gate_active = 1'b1;
    status_osc_running = 1'b1;
    frame_begin();
    spi_byte(8'h81, rx);
    spi_byte(8'h00, rx);
    frame_end();
    check("readback_status", {16'h0, rx}, 24'h03);
    check("miso_idle", {23'h0, spi_miso}, 24'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_wavetable_regfile.md
Name: spi_wavetable_regfile

Overview:
Parametrised SPI Mode 0 (CPOL=0, CPHA=0) register slave for the wavetable synth. It is the successor to the fixed single-voice, 8-sample register block. It adds configurable wavetable depth, NUM_VOICES frequency/volume sets, an explicit read/write command bit, and atomic commit of voice parameters at CS deassert. It sits between the external SPI pins and the oscillator/voice datapath.

Parameters:
WT_DEPTH, 16, wavetable sample count; legal range 2..64.
NUM_VOICES, 2, voice register sets; legal range 1..3.
SYNC_STAGES, 2, synchroniser flops on sck/mosi/cs; legal range ≥2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
spi_sck  input  1  SPI clock, asynchronous to clk
spi_mosi  input  1  SPI data in, MSB first
spi_cs  input  1  chip select, active-low
spi_miso  output  1  SPI data out (see Optional Feature)
status_gate_active  input  1  live gate status
status_osc_running  input  1  live oscillator status
reg_control  output  8  bit0 OSC_EN, bit1 STREAM_MODE, bit2 SW_GATE
reg_status  output  8  {6'b0, status_osc_running, status_gate_active}, combinational
freq_bus  output  24*NUM_VOICES  voice v at bits [24v+23:24v]
volume_bus  output  8*NUM_VOICES  voice v at bits [8v+7:8v]
wavetable_bus  output  8*WT_DEPTH  sample n at bits [8n+7:8n]
commit_pulse  output  1  one-clk strobe when staged voice values go live

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: reg_control 0x00; freq_bus, volume_bus and wavetable_bus all 0; all shadow registers 0; commit_pulse 0; spi_miso 0; FSM in IDLE.
- Synchronisation: sck, mosi and cs each pass through SYNC_STAGES flops. SCK edges are detected from the last two stages. spi_sck must run ≤ clk/8.
- Address map (7-bit):
  - 0x00 control, R/W, immediate write.
  - 0x01 status, read-only; writes ignored.
  - 0x02+4v .. 0x05+4v: voice v freq low, mid, high, then volume; writes are staged.
  - 0x10 .. 0x10+WT_DEPTH-1: wavetable, immediate write.
  - All other addresses: writes ignored, reads return 0x00.
- Frame format: first byte after CS falls = {R/nW, addr[6:0]}. Every following byte is data. The address auto-increments after each data byte, wrapping 0x7F→0x00.
- FSM states:
  - IDLE → CMD when synced cs falls.
  - CMD → DATA after the 8th rising SCK edge.
  - DATA stays in DATA, one byte per 8 rising edges.
  - Any state → IDLE when synced cs rises.
- Bit counter: 3 bits, cleared on cs rising and in IDLE. A partial byte is discarded on cs rise with no write.
- Write latency: the target register updates on the clk after the 8th synced rising edge of the data byte is detected.
- Shadow commit:
  - Voice writes land in shadow registers and set a dirty flag.
  - On synced cs rise with dirty=1, all shadows copy to freq_bus/volume_bus in the same clk, commit_pulse=1 for exactly one clk, and dirty clears.
  - If dirty=0 at cs rise, no commit and no pulse.
- Simultaneous events: a byte completing on the same clk as cs rise is treated as aborted and not written.
- Reset mid-frame: all state returns to reset values and the shadows are lost.

Optional Feature:
SPI_READBACK_EN
- Defined:
  - A read command shifts register data MSB first on spi_miso.
  - The MSB is driven after the 8th falling SCK edge of the command byte. Subsequent bits change after each detected falling edge.
  - Bursts auto-increment.
  - Voice reads return live values, not shadow values.
  - spi_miso is 0 whenever cs is high.
- Undefined:
  - spi_miso is tied to 0.
  - Read commands are decoded, and their data bytes are ignored with no writes.

Test Plan:
- Write cmd 0x00, data 0x05, release CS → reg_control=0x05; commit_pulse stays 0.
- Voice 1 burst: cmd 0x06, then 0x00, 0x40, 0x02, 0x80 → freq_bus[47:24] holds 0 during the frame; after CS rise it reads 0x024000 and volume_bus[15:8]=0x80. commit_pulse is high for exactly 1 clk.
- Wavetable burst: cmd 0x10, then 16 bytes 0,17,…,255 (WT_DEPTH=16) → sample0=0, sample15=255, all intermediate samples correct.
- Abort: cmd 0x02, then CS rises after 5 data bits → freq unchanged; no commit_pulse; the next full frame behaves normally.
- Reset mid-frame: assert rst_n low after the command byte of a voice write → all outputs 0 and FSM back in IDLE; a subsequent write to 0x00 succeeds.
- With SPI_READBACK_EN: write 0xA5 to 0x12, then cmd 0x92 → spi_miso shifts 10100101. A read of 0x01 with both status inputs high returns 0x03.
